// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Each raw button is synchronised, debounced and turned into a clean level
// plus one-cycle press/release pulses.
// Optional hold-to-repeat: define BTN_AUTOREPEAT_EN to add a per-channel
// hold counter that re-issues btn_press while the button stays pressed.

module button_conditioner #(
    parameter int CHANNELS      = 2,
    parameter int DB_CYCLES     = 1000,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_PERIOD = 10000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CHANNELS-1:0] accept;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    // Down-counter: loaded at the accepted press, a repeat fires when it hits 0.
    logic [RPT_W-1:0] rpt [CHANNELS];
`else
    // Repeat timing is meaningless without the hold counter.
    localparam int unused_rpt_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that s2
            // takes the old s1, giving a real two-stage pipeline.
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // A channel accepts a new level once s2 has differed for DB_CYCLES edges.
    always_comb begin
        // NOTE: default assignment first so no path leaves accept unassigned
        // (which would infer a latch).
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = (s2[i] != btn_level[i]) && (cnt[i] == CNT_W'(DB_CYCLES - 1));
        end
    end

    // Debounce counters, level register, pulse registers and optional repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            // NOTE: the counter arrays are small per-channel registers, not a
            // RAM, so they are reset explicitly like any other state.
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
`ifdef BTN_AUTOREPEAT_EN
                rpt[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                btn_press[i]   <= 1'b0;
                btn_release[i] <= 1'b0;

                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    btn_level[i]   <= s2[i];
                    btn_press[i]   <= s2[i];
                    btn_release[i] <= ~s2[i];
                    cnt[i]         <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end

`ifdef BTN_AUTOREPEAT_EN
                // Accepted press arms the first repeat; an accepted release
                // (or idle level) clears it, so release always wins.
                if (accept[i] && s2[i]) begin
                    rpt[i] <= RPT_W'(REPEAT_DELAY - 1);
                end else if (!btn_level[i] || accept[i]) begin
                    rpt[i] <= '0;
                end else if (rpt[i] == '0) begin
                    btn_press[i] <= 1'b1;
                    rpt[i]       <= RPT_W'(REPEAT_PERIOD - 1);
                end else begin
                    rpt[i] <= rpt[i] - RPT_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (CHANNELS=2, DB_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8). Expected pulse events are queued with
// the cycle they must appear in; a monitor pops and compares every cycle.

module tb_button_conditioner;

    localparam int CH  = 2;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = DB + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] btn_press;
    logic [CH-1:0] btn_release;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int       at;
        logic [1:0] press;
        logic [1:0] rel;
    } ev_t;

    ev_t sb[$];

    button_conditioner #(
        .CHANNELS     (CH),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // Cycle index = number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_ev(input int at, input logic [1:0] p, input logic [1:0] r);
        ev_t e;
        e.at    = at;
        e.press = p;
        e.rel   = r;
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 8'(sb.size()), 8'd0);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: every cycle, pulses must match a queued event or be 0.
    always @(negedge clk) begin
        ev_t e;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            check("missed_event", 8'(e.at), 8'(cyc));
        end
        if (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            check("press_event", 8'(btn_press), 8'(e.press));
            check("release_event", 8'(btn_release), 8'(e.rel));
        end else begin
            check("idle_pulses", 8'({btn_press, btn_release}), 8'd0);
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int d;

        // 1. Reset with both buttons held.
        rst_n  = 1'b0;
        btn_in = 2'b11;
        repeat (10) @(negedge clk);
        check("rst_level_mid", 8'(btn_level), 8'd0);
        check("rst_pulses_mid", 8'({btn_press, btn_release}), 8'd0);
        repeat (10) @(negedge clk);
        check("rst_level_end", 8'(btn_level), 8'd0);
        c = cyc;
        rst_n = 1'b1;
        push_ev(c + LAT, 2'b11, 2'b00);
        repeat (LAT - 1) @(negedge clk);
        check("rst_level_pre", 8'(btn_level), 8'b00);
        @(negedge clk);
        check("rst_level_acc", 8'(btn_level), 8'b11);
        @(negedge clk);
        c = cyc;
        btn_in = 2'b00;
        push_ev(c + LAT, 2'b00, 2'b11);
        drain(30);
        check("rst_level_rel", 8'(btn_level), 8'b00);

        // 2. Glitch of 3 cycles on ch0 is rejected.
        @(negedge clk);
        btn_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        btn_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_level_a", 8'(btn_level), 8'b00);
        repeat (8) @(negedge clk);
        check("glitch_level_b", 8'(btn_level), 8'b00);

        // 3. Clean 50-cycle press on ch0.
        @(negedge clk);
        c = cyc;
        btn_in[0] = 1'b1;
        push_ev(c + LAT, 2'b01, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
        push_ev(c + LAT + RD,          2'b01, 2'b00);
        push_ev(c + LAT + RD + RP,     2'b01, 2'b00);
        push_ev(c + LAT + RD + 2 * RP, 2'b01, 2'b00);
        push_ev(c + LAT + RD + 3 * RP, 2'b01, 2'b00);
`endif
        repeat (10) @(negedge clk);
        check("clean_level_held", 8'(btn_level), 8'b01);
        repeat (40) @(negedge clk);
        btn_in[0] = 1'b0;
        push_ev(c + 50 + LAT, 2'b00, 2'b01);
        drain(30);
        check("clean_level_rel", 8'(btn_level), 8'b00);

        // 4. Bouncing ch1 gives a single press after the final rise.
        @(negedge clk);
        c = cyc;
        btn_in[1] = 1'b1;
        repeat (2) @(negedge clk);
        btn_in[1] = 1'b0;
        repeat (2) @(negedge clk);
        btn_in[1] = 1'b1;
        repeat (2) @(negedge clk);
        btn_in[1] = 1'b0;
        repeat (2) @(negedge clk);
        btn_in[1] = 1'b1;
        push_ev(c + 8 + LAT, 2'b10, 2'b00);
        repeat (5) @(negedge clk);
        check("bounce_level_pre", 8'(btn_level), 8'b00);
        repeat (5) @(negedge clk);
        check("bounce_level_acc", 8'(btn_level), 8'b10);
        btn_in[1] = 1'b0;
        push_ev(c + 18 + LAT, 2'b00, 2'b10);
        drain(30);

        // 5. Hold ch0 for 60 cycles; release coincides with a due repeat.
        @(negedge clk);
        c = cyc;
        btn_in[0] = 1'b1;
        push_ev(c + LAT, 2'b01, 2'b00);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++) push_ev(c + LAT + RD + k * RP, 2'b01, 2'b00);
`endif
        repeat (60) @(negedge clk);
        btn_in[0] = 1'b0;
        push_ev(c + 60 + LAT, 2'b00, 2'b01);
        drain(30);

        // 6. Reset two cycles into a ch0 debounce count.
        @(negedge clk);
        c = cyc;
        btn_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midcnt_rst_out", 8'({btn_level, btn_press, btn_release}), 8'd0);
        repeat (3) @(negedge clk);
        d = cyc;
        rst_n = 1'b1;
        push_ev(d + LAT, 2'b01, 2'b00);
        repeat (LAT - 1) @(negedge clk);
        check("midcnt_level_pre", 8'(btn_level), 8'b00);
        @(negedge clk);
        check("midcnt_level_acc", 8'(btn_level), 8'b01);
        @(negedge clk);
        btn_in[0] = 1'b0;
        push_ev(d + LAT + 1 + LAT, 2'b00, 2'b01);
        drain(30);

        // 7. Asynchronous reset while ch1 is held and accepted.
        @(negedge clk);
        c = cyc;
        btn_in[1] = 1'b1;
        push_ev(c + LAT, 2'b10, 2'b00);
        repeat (8) @(negedge clk);
        check("hold_level_before_rst", 8'(btn_level), 8'b10);
        rst_n = 1'b0;
        #1;
        check("hold_level_async_rst", 8'(btn_level), 8'b00);
        repeat (2) @(negedge clk);
        d = cyc;
        rst_n = 1'b1;
        push_ev(d + LAT, 2'b10, 2'b00);
        repeat (LAT) @(negedge clk);
        check("hold_level_fresh", 8'(btn_level), 8'b10);
        btn_in[1] = 1'b0;
        push_ev(d + 2 * LAT, 2'b00, 2'b10);
        drain(30);
        check("final_level", 8'(btn_level), 8'b00);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
